serial_byte_rx: RTL and testbench

- Serial receiver stage that sits directly upstream of the 8-bit register stage.
- Deserialises an asynchronous start/8-data/stop serial line (LSB first) into a parallel byte on Q.
- Issues a one-cycle Valid strobe that serves as the load qualifier for the downstream 8-bit register.
- Flags frames whose stop bit is bad.

---
 rtl/serial_byte_rx.sv | 129 ++++++++++++
 tb/tb_serial_byte_rx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_byte_rx.sv
// Start/8-data/stop serial receiver with a two-flop input synchroniser.
// Q is loaded only on a good stop bit; Valid qualifies the downstream byte register.
module serial_byte_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int WIDTH        = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Rx,
  output logic [WIDTH-1:0] Q,
  output logic             Valid,
  output logic             Frame_Err,
  output logic             Busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  logic [WIDTH-1:0] r_shift;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;

  // Flops reset high so a reset never looks like a start bit.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      Q         <= '0;
      Valid     <= 1'b0;
      Frame_Err <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      Valid     <= 1'b0;
      Frame_Err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
            Busy    <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
              Busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            // LSB first: after WIDTH shifts bit 0 sits at r_shift[0].
            r_shift   <= {w_rx_s, r_shift[WIDTH-1:1]};
            r_bit_idx <= r_bit_idx + IDX_W'(1);
            if (r_bit_idx == LAST_IDX) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              Q       <= r_shift;
              Valid   <= 1'b1;
              r_state <= S_IDLE;
              Busy    <= 1'b0;
            end else begin
              Frame_Err <= 1'b1;
              r_state   <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A line stuck low after a bad stop must not start a new frame.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_rx.sv
// Scoreboard bench for serial_byte_rx: stimulus pushes expected pulses,
// a negedge monitor pops and checks kind, Q and arrival cycle.
module tb_serial_byte_rx;
  localparam int C   = 4;
  localparam int W   = 8;
  localparam int LAT = 2 + C / 2 + 9 * C;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Rx  = 1'b1;
  logic [W-1:0] Q;
  logic         Valid;
  logic         Frame_Err;
  logic         Busy;

  serial_byte_rx #(.CLKS_PER_BIT(C), .WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .Q(Q),
    .Valid(Valid), .Frame_Err(Frame_Err), .Busy(Busy)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic        err;
    logic [7:0]  q;
    logic [31:0] cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q   = 8'h00;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (Rst && (Valid || Frame_Err)) begin
      exp_t e;
      chk("pulse_exclusive", {31'd0, Valid & Frame_Err}, 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got Valid=%0b Frame_Err=%0b Q=%0h expected none (cycle %0d)",
                 Valid, Frame_Err, Q, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, Frame_Err}, {31'd0, e.err});
        chk("pulse_q", {24'd0, Q}, {24'd0, e.q});
        chk("pulse_cycle", cyc, e.cyc);
        if (Valid) chk("busy_on_valid", {31'd0, Busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; the following posedge is the first to sample Rx low.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err = ~stop;
    e.q   = stop ? d : exp_q;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    if (stop) exp_q = d;
    Rx = 1'b0;
    repeat (C) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      repeat (C) @(negedge Clk);
    end
    Rx = stop;
    repeat (C) @(negedge Clk);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0;
    Rx  = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_q", {24'd0, Q}, 32'd0);
    chk("reset_valid", {31'd0, Valid}, 32'd0);
    chk("reset_ferr", {31'd0, Frame_Err}, 32'd0);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    Rst = 1'b1;
    repeat (5) @(negedge Clk);

    // Single good frame
    send_frame(8'hA5, 1'b1);
    Rx = 1'b1;
    repeat (8) @(negedge Clk);
    chk("a5_busy_after", {31'd0, Busy}, 32'd0);
    chk("a5_q_held", {24'd0, Q}, 32'hA5);

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 1'b1);
    send_frame(8'h81, 1'b1);
    send_frame(8'hFF, 1'b1);
    Rx = 1'b1;
    repeat (8) @(negedge Clk);
    chk("b2b_q_last", {24'd0, Q}, 32'hFF);

    // Bad stop bit, line held low
    send_frame(8'h3C, 1'b0);
    repeat (20) @(negedge Clk);
    chk("wait_high_busy", {31'd0, Busy}, 32'd1);
    chk("ferr_q_kept", {24'd0, Q}, 32'hFF);
    Rx = 1'b1;
    repeat (12) @(negedge Clk);
    chk("wait_high_released", {31'd0, Busy}, 32'd0);
    send_frame(8'h55, 1'b1);
    Rx = 1'b1;
    repeat (8) @(negedge Clk);
    chk("after_ferr_q", {24'd0, Q}, 32'h55);

    // One-cycle glitch: reaches START, then aborts
    Rx = 1'b0;
    @(negedge Clk);
    Rx = 1'b1;
    repeat (3) @(negedge Clk);
    chk("glitch_in_start", {31'd0, Busy}, 32'd1);
    repeat (40) @(negedge Clk);
    chk("glitch_idle", {31'd0, Busy}, 32'd0);
    chk("glitch_q_kept", {24'd0, Q}, 32'h55);

    // Reset during data bit 3 of 0xF0 (bits 0..3 are all 0)
    Rx = 1'b0;
    repeat (C) @(negedge Clk);
    repeat (3 * C) @(negedge Clk);
    repeat (C / 2) @(negedge Clk);
    chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("midreset_q", {24'd0, Q}, 32'd0);
    chk("midreset_busy", {31'd0, Busy}, 32'd0);
    chk("midreset_valid", {31'd0, Valid}, 32'd0);
    exp_q = 8'h00;
    Rst = 1'b1;
    Rx  = 1'b1;
    repeat (60) @(negedge Clk);
    chk("after_reset_busy", {31'd0, Busy}, 32'd0);
    send_frame(8'h0F, 1'b1);
    Rx = 1'b1;
    repeat (8) @(negedge Clk);
    chk("after_reset_q", {24'd0, Q}, 32'h0F);

    // All-zero data with good stop
    send_frame(8'h00, 1'b1);
    Rx = 1'b1;
    repeat (8) @(negedge Clk);
    chk("zero_q", {24'd0, Q}, 32'h00);
    chk("zero_busy", {31'd0, Busy}, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
